// File: rtl/inst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer_if
// Description : Bundles the sequencer's control, fetch, flag and status
//               signals. The master modport is the sequencer side. The slave
//               modport is the instruction memory / datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_sequencer_if #(
    parameter int PC_WIDTH = 4
);
    logic                start;
    logic [31:0]         inst;
    logic                stall;
    logic                sign;
    logic                zero;
    logic                overflow;
    logic                carry;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         ir;
    logic                exec_en;
    logic                busy;
    logic                halted;

    modport master (
        input  start, inst, stall, sign, zero, overflow, carry,
        output pc, ir, exec_en, busy, halted
    );

    modport slave (
        output start, inst, stall, sign, zero, overflow, carry,
        input  pc, ir, exec_en, busy, halted
    );
endinterface
`default_nettype wire

// File: rtl/inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inst_sequencer
// Description : Multi-cycle instruction sequencer. It owns the PC and fetches
//               into the IR. It resolves jump and halt opcodes locally and
//               strobes exec_en once per datapath op. Each instruction runs
//               FETCH, DECODE, EXEC, EXEC_CYCLES x WAIT, NEXT.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_sequencer #(
    parameter int PC_WIDTH    = 4,
    parameter int EXEC_CYCLES = 4   // 1..15
) (
    input  wire logic           clk,
    input  wire logic           sys_rst,   // asynchronous, active low
    inst_sequencer_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_NEXT   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [4:0] c_OP_JUMP   = 5'b10010;
    localparam logic [4:0] c_OP_JC     = 5'b10011;
    localparam logic [4:0] c_OP_JNC    = 5'b10100;
    localparam logic [4:0] c_OP_JS     = 5'b10101;
    localparam logic [4:0] c_OP_JNS    = 5'b10110;
    localparam logic [4:0] c_OP_JZ     = 5'b10111;
    localparam logic [4:0] c_OP_JNZ    = 5'b11000;
    localparam logic [4:0] c_OP_JO     = 5'b11001;
    localparam logic [4:0] c_OP_JNO    = 5'b11010;
    localparam logic [4:0] c_OP_HALT   = 5'b11011;
    localparam logic [3:0] c_LAST_WAIT = 4'(EXEC_CYCLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_ir;
    logic [3:0]          r_count;
    logic                r_take_jump;
    logic                r_exec_en;
    logic                r_busy;
    logic                r_halted;

    logic [4:0]          w_opcode;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_is_halt;
    logic                w_is_dp;
    logic                w_cond;

    assign w_opcode  = r_ir[31:27];
    assign w_target  = r_ir[PC_WIDTH-1:0];
    assign w_is_halt = (w_opcode == c_OP_HALT);
    // Opcodes below the first jump opcode go to the datapath. Reserved codes
    // above halt fall through as no-ops.
    assign w_is_dp   = (w_opcode < c_OP_JUMP);

    // Evaluate the jump condition against the live flags. Non-jumps never jump.
    always_comb begin
        w_cond = 1'b0;
        case (w_opcode)
            c_OP_JUMP: w_cond = 1'b1;
            c_OP_JC:   w_cond = bus.carry;
            c_OP_JNC:  w_cond = ~bus.carry;
            c_OP_JS:   w_cond = bus.sign;
            c_OP_JNS:  w_cond = ~bus.sign;
            c_OP_JZ:   w_cond = bus.zero;
            c_OP_JNZ:  w_cond = ~bus.zero;
            c_OP_JO:   w_cond = bus.overflow;
            c_OP_JNO:  w_cond = ~bus.overflow;
            default:   w_cond = 1'b0;
        endcase
    end

    // Next-state logic. start and stall are only looked at where they matter.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC:   w_next_state = S_WAIT;
            S_WAIT:   if (!bus.stall && (r_count == c_LAST_WAIT)) w_next_state = S_NEXT;
            S_NEXT:   w_next_state = S_FETCH;
            S_HALT:   if (bus.start) w_next_state = S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // PC, IR, wait counter and the jump decision, each updated in its own state.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_count     <= '0;
            r_take_jump <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  r_ir        <= bus.inst;
                S_DECODE: r_take_jump <= w_cond;
                S_EXEC:   r_count     <= '0;
                S_WAIT:   if (!bus.stall) r_count <= r_count + 4'd1;
                S_NEXT:   r_pc        <= r_take_jump ? w_target : r_pc + PC_WIDTH'(1);
                S_HALT:   if (bus.start) r_pc <= '0;
                default:  ;
            endcase
        end
    end

    // Status outputs are registered from the next state, so they line up with it.
    // exec_en fires in EXEC only for datapath ops.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_exec_en <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_exec_en <= (r_state == S_DECODE) && w_is_dp;
            r_busy    <= (w_next_state != S_IDLE) && (w_next_state != S_HALT);
            r_halted  <= (w_next_state == S_HALT);
        end
    end

    assign bus.pc      = r_pc;
    assign bus.ir      = r_ir;
    assign bus.exec_en = r_exec_en;
    assign bus.busy    = r_busy;
    assign bus.halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_inst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_sequencer
// Description : Self-checking bench for inst_sequencer. A small program
//               memory feeds inst. Each expected exec_en pulse is queued with
//               its PC/IR and spacing, and is checked as the pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_sequencer;

    localparam int PC_WIDTH    = 4;
    localparam int EXEC_CYCLES = 4;

    localparam logic [31:0] c_NOP  = 32'hE000_0000;  // reserved opcode 11100
    localparam logic [31:0] c_HALT = 32'hD800_0000;  // opcode 11011

    typedef struct {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         ir;
        int                  gap;   // cycles since previous pulse, 0 = don't care
    } exp_t;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic [31:0] mem [16];
    exp_t        q_exp[$];
    exp_t        e_mon;
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          cyc       = 0;
    int          last_exec = 0;
    int          n_exec    = 0;
    int          base_exec;

    inst_sequencer_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    assign bus.inst = mem[bus.pc];

    inst_sequencer #(
        .PC_WIDTH   (PC_WIDTH),
        .EXEC_CYCLES(EXEC_CYCLES)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [PC_WIDTH-1:0] pc, input int gap);
        exp_t e;
        e.pc  = pc;
        e.ir  = mem[pc];
        e.gap = gap;
        q_exp.push_back(e);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) mem[i] = c_NOP;
    endtask

    task automatic wait_halted();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.halted === 1'b1) break;
        end
        chk("halt_seen", {31'd0, bus.halted}, 32'd1);
    endtask

    task automatic wait_pc(input logic [PC_WIDTH-1:0] target);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pc === target) break;
        end
        chk("reach_pc", {28'd0, bus.pc}, {28'd0, target});
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Compare every exec_en pulse against the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (bus.exec_en === 1'b1) begin
            n_exec++;
            if (q_exp.size() == 0) begin
                chk("exec_unexpected", 32'd1, 32'd0);
            end else begin
                e_mon = q_exp.pop_front();
                chk("exec_pc", {28'd0, bus.pc}, {28'd0, e_mon.pc});
                chk("exec_ir", bus.ir, e_mon.ir);
                if (e_mon.gap != 0) chk("exec_gap", cyc - last_exec, e_mon.gap);
            end
            last_exec = cyc;
        end
    end

    // Variant runner for the conditional jump at address 2, restarted from HALT.
    task automatic run_jump(input string tag, input logic [31:0] jop, input logic z,
                            input logic c, input logic [PC_WIDTH-1:0] exp_pc);
        mem[2]   = jop;
        bus.zero  = z;
        bus.carry = c;
        push_exp(4'd0, 0);
        push_exp(4'd1, 8);
        pulse_start();
        chk({tag, "_restart_pc"}, {28'd0, bus.pc}, 32'd0);
        chk({tag, "_restart_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_restart_halted"}, {31'd0, bus.halted}, 32'd0);
        wait_halted();
        chk({tag, "_halt_pc"}, {28'd0, bus.pc}, {28'd0, exp_pc});
        chk({tag, "_queue_empty"}, q_exp.size(), 32'd0);
    endtask

    initial begin
        sys_rst      = 1'b0;
        bus.start    = 1'b0;
        bus.stall    = 1'b0;
        bus.sign     = 1'b0;
        bus.zero     = 1'b0;
        bus.overflow = 1'b0;
        bus.carry    = 1'b0;
        fill_nop();

        // ---------------- reset, start and sequential program ----------------
        mem[0] = 32'h0000_1111;
        mem[1] = 32'h0800_2222;
        mem[2] = 32'h4000_3333;
        mem[3] = 32'h8800_4444;   // opcode 10001, last datapath opcode
        mem[4] = c_HALT;
        repeat (3) @(negedge clk);
        chk("rst_pc", {28'd0, bus.pc}, 32'd0);
        chk("rst_ir", bus.ir, 32'd0);
        chk("rst_exec", {31'd0, bus.exec_en}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        n_exec = 0;
        push_exp(4'd0, 0);
        push_exp(4'd1, 8);
        push_exp(4'd2, 8);
        push_exp(4'd3, 8);
        pulse_start();                                  // FETCH cycle
        chk("fetch_busy", {31'd0, bus.busy}, 32'd1);
        chk("fetch_ir", bus.ir, 32'd0);
        @(negedge clk);                                 // DECODE
        chk("decode_ir", bus.ir, mem[0]);
        @(negedge clk);                                 // EXEC
        chk("exec_pulse", {31'd0, bus.exec_en}, 32'd1);
        @(negedge clk);
        chk("exec_one_cycle", {31'd0, bus.exec_en}, 32'd0);
        repeat (5) @(negedge clk);                      // 8 cycles after FETCH
        chk("pc_advance", {28'd0, bus.pc}, 32'd1);
        wait_halted();
        chk("seq_halt_pc", {28'd0, bus.pc}, 32'd4);
        chk("seq_busy", {31'd0, bus.busy}, 32'd0);
        chk("seq_exec_count", n_exec, 32'd4);
        chk("seq_queue_empty", q_exp.size(), 32'd0);

        // ---------------- conditional jumps ----------------
        fill_nop();
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h0800_0002;
        mem[3] = c_HALT;
        mem[9] = c_HALT;
        run_jump("jz_taken",   32'hB800_FFF9, 1'b1, 1'b0, 4'd9);
        run_jump("jz_not",     32'hB800_FFF9, 1'b0, 1'b0, 4'd3);
        run_jump("jnc_taken",  32'hA000_0009, 1'b0, 1'b0, 4'd9);
        run_jump("jnc_not",    32'hA000_0009, 1'b1, 1'b1, 4'd3);

        // ---------------- stall and PC wrap ----------------
        fill_nop();
        mem[0]   = 32'hC000_000F;  // jnozero 15
        mem[1]   = c_HALT;
        mem[15]  = 32'h1000_0F0F;
        bus.zero  = 1'b0;
        bus.carry = 1'b0;
        push_exp(4'd15, 0);
        pulse_start();
        wait_pc(4'd15);                                 // FETCH of address 15
        bus.zero = 1'b1;                                // second pass falls through
        @(negedge clk);                                 // DECODE
        bus.stall = 1'b1;                               // ignored until WAIT
        @(negedge clk);                                 // EXEC
        chk("stall_exec", {31'd0, bus.exec_en}, 32'd1);
        repeat (6) @(negedge clk);                      // 5 stalled WAIT cycles
        bus.stall = 1'b0;
        repeat (4) @(negedge clk);                      // NEXT
        chk("stall_pc_hold", {28'd0, bus.pc}, 32'd15);
        @(negedge clk);                                 // 13 cycles after FETCH
        chk("wrap_pc", {28'd0, bus.pc}, 32'd0);
        chk("wrap_busy", {31'd0, bus.busy}, 32'd1);
        wait_halted();
        chk("wrap_halt_pc", {28'd0, bus.pc}, 32'd1);
        chk("wrap_queue_empty", q_exp.size(), 32'd0);

        // ---------------- reset abort during WAIT ----------------
        fill_nop();
        mem[0] = 32'h0000_00AA;
        mem[1] = 32'h0800_00BB;
        mem[2] = 32'h0800_00CC;
        mem[3] = c_HALT;
        push_exp(4'd0, 0);
        push_exp(4'd1, 8);
        pulse_start();
        wait_pc(4'd1);                                  // FETCH of address 1
        repeat (4) @(negedge clk);                      // inside WAIT
        sys_rst = 1'b0;
        #1;
        chk("abort_pc", {28'd0, bus.pc}, 32'd0);
        chk("abort_ir", bus.ir, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_exec", {31'd0, bus.exec_en}, 32'd0);
        repeat (2) @(negedge clk);
        sys_rst   = 1'b1;
        base_exec = n_exec;
        repeat (20) @(negedge clk);
        chk("abort_no_exec", n_exec - base_exec, 32'd0);
        chk("abort_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_idle_pc", {28'd0, bus.pc}, 32'd0);
        chk("abort_queue_empty", q_exp.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/inst_sequencer.md
# inst_sequencer

Multi-cycle instruction sequencer for the 16-entry single-issue core. It owns the program counter, fetches each 32-bit word from instruction memory into the instruction register and issues a one-cycle execute strobe to the ALU/register/data-memory datapath. It resolves jump and halt opcodes locally from the datapath condition flags. It replaces the free-running count-to-4 PC advance with an explicit start/halt/stall-aware state machine.

## Interface
- PC_WIDTH, 4, program counter width; instruction memory depth 2^PC_WIDTH
- EXEC_CYCLES, 4, WAIT-state cycles per instruction; legal range 1..15

- clk  in  1  single clock, rising edge
- sys_rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  level; sampled in IDLE and HALT only
- inst  in  32  instruction word at inst_mem[pc], combinational from pc
- stall  in  1  datapath wait request; honoured in WAIT only
- sign, zero, overflow, carry  in  1 each  registered datapath condition flags
- pc  out  PC_WIDTH  program counter, addresses instruction memory
- ir  out  32  latched instruction register, drives datapath decode
- exec_en  out  1  one-cycle execute strobe to the datapath
- busy  out  1  high in FETCH, DECODE, EXEC, WAIT and NEXT
- halted  out  1  high in HALT

## Operation
- IR fields: opcode ir[31:27], immediate ir[15:0]. Jump target is ir[PC_WIDTH-1:0]; upper immediate bits are ignored.
- Control opcodes, all decoded in DECODE:
  - 10010 jump
  - 10011 jcarry, 10100 jnocarry
  - 10101 jsign, 10110 jnosign
  - 10111 jzero, 11000 jnozero
  - 11001 joverflow, 11010 jnooverflow
  - 11011 halt
- Reserved opcodes 11100–11111 are no-ops: exec_en stays 0 and pc advances.
- All other opcodes (00000–10001) are datapath ops: exec_en pulses in EXEC.
- States:
  - IDLE: wait for start=1, then go to FETCH with pc unchanged (0 after reset).
  - FETCH: ir <= inst; go to DECODE.
  - DECODE: latch take_jump, the condition evaluated from the current flag inputs. Go to HALT if the opcode is halt, else EXEC.
  - EXEC: exec_en=1 for datapath ops only; counter <= 0; go to WAIT.
  - WAIT: if stall=1 hold, counter frozen. Else counter++; when counter reaches EXEC_CYCLES-1 go to NEXT.
  - NEXT: pc <= take_jump ? target : pc+1; go to FETCH.
  - HALT: pc holds the halt instruction's address. On start=1, pc <= 0 and go to FETCH.
- PC arithmetic is modulo 2^PC_WIDTH: pc = 2^PC_WIDTH-1 plus 1 wraps to 0.
- Flags are whatever the datapath holds when DECODE samples them, i.e. the result of the last executed datapath op. Jumps do not modify flags.
- stall outside WAIT is ignored. start outside IDLE/HALT is ignored.

## Timing
- Reset (sys_rst=0, asynchronous):
  - state=IDLE, pc=0, ir=0, counter=0, take_jump=0
  - exec_en=0, busy=0, halted=0
- Reset mid-instruction aborts immediately to the reset values. No exec_en is issued after reset assertion.
- Without stall, each instruction takes 4+EXEC_CYCLES cycles (FETCH, DECODE, EXEC, EXEC_CYCLES×WAIT, NEXT); 8 cycles at default.
- Each stalled WAIT cycle adds exactly one cycle.
- exec_en is high for exactly one cycle per datapath op, in EXEC, two cycles after the FETCH cycle.
- The first FETCH follows the cycle in which start=1 is sampled in IDLE.
- pc changes only on the NEXT→FETCH edge, or on the HALT→FETCH edge (to 0).
- halted asserts the cycle after DECODE of a halt opcode. busy falls in that same cycle.
- All outputs are registered. ir is stable from the cycle after FETCH until the next FETCH.

## Test plan
- Reset/start: hold sys_rst=0 for 3 cycles, release, pulse start. Expect pc=0, ir=0, exec_en=0 before start; FETCH on the next cycle; ir=inst_mem[0] one cycle later; exec_en pulse 2 cycles after FETCH; pc=1 eight cycles after the first FETCH.
- Sequential program: 4 add/mov instructions then halt at address 4. Expect exactly 4 exec_en pulses 8 cycles apart, halted=1, pc=4, busy=0.
- Conditional jumps: at pc=2, jzero to 9.
  - With zero=1: next pc=9 and no exec_en for the jump.
  - With zero=0: pc=3.
  - Repeat for jnocarry with carry=0 (taken) and carry=1 (not taken).
- Stall and wrap: assert stall for 5 cycles in WAIT at pc=15. Expect the instruction to take 13 cycles, a single exec_en, and pc to wrap to 0.
- Restart/abort: in HALT, pulse start and expect pc=0 with a fresh FETCH. Separately, assert sys_rst=0 during WAIT and expect an immediate return to IDLE, pc=0, and no further exec_en.
